// File: rtl/imem_load_arbiter.sv
// Purpose: shares the instruction-memory address/write port between fetch and a byte-serial image loader.
// Latency: grant/address/write-enable are combinational; fetch_fault and load_err are registered (1 cycle).
// Backpressure: byte_ready is high only in LOAD without abort; fetch is stalled (fetch_grant=0) in LOAD/DRAIN.
module imem_load_arbiter #(
   parameter int INST_MEM_DEPTH = 2048,
   parameter int WORD_CNT_W     = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           fetch_addr,
   output logic                  fetch_grant,
   output logic                  fetch_fault,
   input  logic                  load_start,
   input  logic [31:0]           load_base,
   input  logic [WORD_CNT_W-1:0] load_words,
   input  logic                  load_abort,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic [31:0]           mem_addr,
   output logic [3:0]            mem_we,
   output logic [31:0]           mem_wdata,
   output logic                  load_busy,
   output logic                  load_done,
   output logic                  load_err
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

   localparam logic [WORD_CNT_W-1:0] ONE_W = WORD_CNT_W'(1);

   state_t                r_state;
   state_t                w_next;
   logic [1:0]            r_lane_cnt;
   logic [WORD_CNT_W-1:0] r_word_cnt;
   logic [WORD_CNT_W-1:0] r_count;
   logic [31:0]           r_base;
   logic                  r_fetch_fault;
   logic                  r_load_err;

   logic [32:0]           w_req_end;
   logic                  w_req_ok;
   logic                  w_fetch_bad;
   logic                  w_accept;
   logic                  w_last_byte;

   // End of the requested region is formed in 33 bits so a base near 2^32 cannot wrap past the bound.
   assign w_req_end   = {1'b0, load_base} + 33'({load_words, 2'b00});
   assign w_req_ok    = (load_base[1:0] == 2'b00) && (load_words != '0) &&
                        (w_req_end <= 33'(INST_MEM_DEPTH));
   assign w_fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= 32'(INST_MEM_DEPTH));
   // Abort wins over a byte offered in the same cycle.
   assign w_accept    = (r_state == S_LOAD) && byte_valid && !load_abort;
   assign w_last_byte = w_accept && (r_lane_cnt == 2'd3) && (r_word_cnt == r_count - ONE_W);

   assign mem_wdata   = {4{byte_data}};
   assign fetch_fault = r_fetch_fault;
   assign load_err    = r_load_err;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (load_start && w_req_ok) w_next = S_LOAD;
         S_LOAD: begin
            if (load_abort)       w_next = S_IDLE;
            else if (w_last_byte) w_next = S_DRAIN;
         end
         S_DRAIN: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Load bookkeeping (base, count, lane/word counters) and registered status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lane_cnt    <= 2'd0;
         r_word_cnt    <= '0;
         r_count       <= '0;
         r_base        <= '0;
         r_fetch_fault <= 1'b0;
         r_load_err    <= 1'b0;
      end else begin
         r_fetch_fault <= (r_state == S_IDLE) && w_fetch_bad;
         r_load_err    <= (r_state == S_IDLE) && load_start && !w_req_ok;
         if ((r_state == S_IDLE) && load_start && w_req_ok) begin
            r_base     <= load_base;
            r_count    <= load_words;
            r_lane_cnt <= 2'd0;
            r_word_cnt <= '0;
         end else if (w_accept) begin
            r_lane_cnt <= r_lane_cnt + 2'd1;
            if (r_lane_cnt == 2'd3) r_word_cnt <= r_word_cnt + ONE_W;
         end
      end
   end

   // Output decode: port ownership, write strobes and status
   always_comb begin
      fetch_grant = 1'b0;
      byte_ready  = 1'b0;
      mem_we      = 4'b0000;
      mem_addr    = r_base + 32'({r_word_cnt, 2'b00});
      load_busy   = 1'b0;
      load_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            fetch_grant = 1'b1;
            mem_addr    = {fetch_addr[31:2], 2'b00};
         end
         S_LOAD: begin
            byte_ready = !load_abort;
            load_busy  = 1'b1;
            if (w_accept) mem_we = 4'b0001 << r_lane_cnt;
         end
         S_DRAIN: begin
            load_busy = 1'b1;
            load_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter: hand-written vector table, corner sequences, then random traffic.
// Expected values come from a byte-indexed reference model and a bench-side memory image.
// Inputs change 1ns after the rising edge; outputs are sampled 4ns after the edge.
module tb_imem_load_arbiter;

   localparam int DEPTH = 2048;
   localparam int WCW   = 10;

   logic            clk;
   logic            rst;
   logic [31:0]     fetch_addr;
   logic            fetch_grant;
   logic            fetch_fault;
   logic            load_start;
   logic [31:0]     load_base;
   logic [WCW-1:0]  load_words;
   logic            load_abort;
   logic            byte_valid;
   logic [7:0]      byte_data;
   logic            byte_ready;
   logic [31:0]     mem_addr;
   logic [3:0]      mem_we;
   logic [31:0]     mem_wdata;
   logic            load_busy;
   logic            load_done;
   logic            load_err;

   imem_load_arbiter #(.INST_MEM_DEPTH(DEPTH), .WORD_CNT_W(WCW)) dut (
      .clk(clk), .rst(rst),
      .fetch_addr(fetch_addr), .fetch_grant(fetch_grant), .fetch_fault(fetch_fault),
      .load_start(load_start), .load_base(load_base), .load_words(load_words),
      .load_abort(load_abort), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Memory image as the instruction RAM would store it, built from the DUT's write port.
   logic [7:0] mem     [DEPTH];
   logic [7:0] exp_mem [DEPTH];

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (mem_we[k] && (mem_addr + k < DEPTH)) mem[mem_addr + k] <= mem_wdata[8*k +: 8];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: 0=idle, 1=loading, 2=drain; progress tracked as a byte index into the image.
   int          m_mode, n_mode;
   int unsigned m_base, n_base, m_nb, n_nb, m_total, n_total;
   logic        m_fault, n_fault, m_err, n_err;

   task automatic pre();
      logic        e_grant, e_ready, e_busy, e_done, e_ca;
      logic [3:0]  e_we;
      logic [31:0] e_addr;
      longint      end_a;
      #3;
      e_grant = 0; e_ready = 0; e_busy = 0; e_done = 0; e_ca = 0; e_we = 0; e_addr = 0;
      n_mode = m_mode; n_base = m_base; n_nb = m_nb; n_total = m_total;
      n_fault = 0; n_err = 0;
      case (m_mode)
         0: begin
            e_grant = 1; e_ca = 1;
            e_addr  = fetch_addr - (fetch_addr % 4);
            n_fault = (fetch_addr % 4 != 0) || (fetch_addr >= DEPTH);
            if (load_start) begin
               end_a = longint'(load_base) + 4 * longint'(load_words);
               if ((load_base % 4 == 0) && (load_words != 0) && (end_a <= DEPTH)) begin
                  n_mode = 1; n_base = load_base; n_nb = 0; n_total = 4 * load_words;
               end else n_err = 1;
            end
         end
         1: begin
            e_busy = 1; e_ready = !load_abort; e_ca = 1;
            e_addr = m_base + 4 * (m_nb / 4);
            if (load_abort) n_mode = 0;
            else if (byte_valid) begin
               e_we = 4'(1 << (m_nb % 4));
               if (m_base + m_nb < DEPTH) exp_mem[m_base + m_nb] = byte_data;
               n_nb = m_nb + 1;
               if (n_nb == m_total) n_mode = 2;
            end
         end
         default: begin
            e_busy = 1; e_done = 1; n_mode = 0;
         end
      endcase
      if (rst) begin n_mode = 0; n_fault = 0; n_err = 0; end
      chk("m_grant", 32'(fetch_grant), 32'(e_grant));
      chk("m_ready", 32'(byte_ready), 32'(e_ready));
      chk("m_we", 32'(mem_we), 32'(e_we));
      chk("m_busy", 32'(load_busy), 32'(e_busy));
      chk("m_done", 32'(load_done), 32'(e_done));
      if (e_we != 0) chk("m_wdata", mem_wdata, {4{byte_data}});
      if (e_ca) chk("m_addr", mem_addr, e_addr);
   endtask

   task automatic post();
      @(posedge clk);
      m_mode = n_mode; m_base = n_base; m_nb = n_nb; m_total = n_total;
      m_fault = n_fault; m_err = n_err;
      #1;
      chk("m_fault", 32'(fetch_fault), 32'(m_fault));
      chk("m_err", 32'(load_err), 32'(m_err));
   endtask

   task automatic drv(input logic r, input logic [31:0] fa, input logic st, input logic [31:0] b,
                      input logic [WCW-1:0] w, input logic ab, input logic bv, input logic [7:0] bd);
      rst = r; fetch_addr = fa; load_start = st; load_base = b; load_words = w;
      load_abort = ab; byte_valid = bv; byte_data = bd;
   endtask

   task automatic step();
      pre();
      post();
   endtask

   function automatic logic [31:0] rd_word(input int a);
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction

   typedef struct packed {
      logic           rst;
      logic [31:0]    fa;
      logic           st;
      logic [31:0]    base;
      logic [WCW-1:0] words;
      logic           ab;
      logic           bv;
      logic [7:0]     bd;
      logic           e_grant;
      logic           ca;
      logic [31:0]    e_addr;
      logic [3:0]     e_we;
      logic           e_rdy;
      logic           e_busy;
      logic           e_done;
      logic           e_fault;
      logic           e_err;
   } vec_t;

   vec_t tv[$];

   initial begin
      logic [7:0] old18;
      for (int i = 0; i < DEPTH; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end
      m_mode = 0; m_base = 0; m_nb = 0; m_total = 0; m_fault = 0; m_err = 0;

      // rst fa st base words ab bv bd | grant ca addr we rdy busy done | fault err (after edge)
      tv.push_back('{1'b0, 32'd0,    1'b0, 32'd0,    10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd4,    1'b0, 32'd0,    10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd4,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd2044, 1'b0, 32'd0,    10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd2044, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd4,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      tv.push_back('{1'b0, 32'd2048, 1'b0, 32'd0,    10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd2048, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      tv.push_back('{1'b0, 32'd0,    1'b1, 32'd0,    10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      tv.push_back('{1'b0, 32'd0,    1'b1, 32'd6,    10'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      tv.push_back('{1'b0, 32'd0,    1'b1, 32'd2044, 10'd2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      tv.push_back('{1'b0, 32'd0,    1'b0, 32'd0,    10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd0,    1'b1, 32'd8,    10'd2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 32'd8,    4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b1, 32'd8,    4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b1, 32'd0,    10'd1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 32'd8,    4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 32'd8,    4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd8,    4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b1, 8'h14, 1'b0, 1'b1, 32'd8,    4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b1, 32'd12,   4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b1, 8'h16, 1'b0, 1'b1, 32'd12,   4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd12,   4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b1, 8'h17, 1'b0, 1'b1, 32'd12,   4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b1, 8'h18, 1'b0, 1'b1, 32'd12,   4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd5,    1'b0, 32'd0,    10'd0, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 32'd0,    4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      tv.push_back('{1'b0, 32'd8,    1'b0, 32'd0,    10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd8,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

      // Reset: hold two edges, then check reset values.
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      #3;
      chk("rst_grant", 32'(fetch_grant), 32'd1);
      chk("rst_busy",  32'(load_busy),   32'd0);
      chk("rst_ready", 32'(byte_ready),  32'd0);
      chk("rst_we",    32'(mem_we),      32'd0);
      chk("rst_done",  32'(load_done),   32'd0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_err",   32'(load_err),    32'd0);
      @(posedge clk);
      #1;

      // Table vectors
      foreach (tv[i]) begin
         drv(tv[i].rst, tv[i].fa, tv[i].st, tv[i].base, tv[i].words, tv[i].ab, tv[i].bv, tv[i].bd);
         pre();
         chk($sformatf("tv%0d_grant", i), 32'(fetch_grant), 32'(tv[i].e_grant));
         chk($sformatf("tv%0d_we", i),    32'(mem_we),      32'(tv[i].e_we));
         chk($sformatf("tv%0d_rdy", i),   32'(byte_ready),  32'(tv[i].e_rdy));
         chk($sformatf("tv%0d_busy", i),  32'(load_busy),   32'(tv[i].e_busy));
         chk($sformatf("tv%0d_done", i),  32'(load_done),   32'(tv[i].e_done));
         if (tv[i].ca) chk($sformatf("tv%0d_addr", i), mem_addr, tv[i].e_addr);
         post();
         chk($sformatf("tv%0d_fault", i), 32'(fetch_fault), 32'(tv[i].e_fault));
         chk($sformatf("tv%0d_err", i),   32'(load_err),    32'(tv[i].e_err));
      end
      chk("rdback_8",  rd_word(8),  32'h14131211);
      chk("rdback_12", rd_word(12), 32'h18171615);

      // Abort on the third byte of the first word
      old18 = mem[18];
      drv(0, 0, 1, 16, 1, 0, 0, 0); step();
      drv(0, 0, 0, 0, 0, 0, 1, 8'hA1); step();
      drv(0, 0, 0, 0, 0, 0, 1, 8'hA2); step();
      drv(0, 0, 0, 0, 0, 1, 1, 8'hA3);
      pre();
      chk("abort_we",  32'(mem_we),     32'd0);
      chk("abort_rdy", 32'(byte_ready), 32'd0);
      post();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      pre();
      chk("abort_grant", 32'(fetch_grant), 32'd1);
      chk("abort_done",  32'(load_done),   32'd0);
      chk("abort_busy",  32'(load_busy),   32'd0);
      post();
      chk("abort_err",  32'(load_err), 32'd0);
      chk("abort_b16",  32'(mem[16]),  32'h000000A1);
      chk("abort_b17",  32'(mem[17]),  32'h000000A2);
      chk("abort_b18",  32'(mem[18]),  32'(old18));

      // Reset after five accepted bytes, then a fresh load must start at lane 0
      drv(0, 0, 1, 64, 2, 0, 0, 0); step();
      for (int b = 0; b < 5; b++) begin
         drv(0, 0, 0, 0, 0, 0, 1, 8'(8'hC0 + b)); step();
      end
      drv(1, 0, 0, 0, 0, 0, 0, 0); step();
      drv(0, 32'd100, 0, 0, 0, 0, 0, 0);
      pre();
      chk("rstmid_grant", 32'(fetch_grant), 32'd1);
      chk("rstmid_busy",  32'(load_busy),   32'd0);
      chk("rstmid_rdy",   32'(byte_ready),  32'd0);
      chk("rstmid_we",    32'(mem_we),      32'd0);
      chk("rstmid_done",  32'(load_done),   32'd0);
      chk("rstmid_fault", 32'(fetch_fault), 32'd0);
      chk("rstmid_addr",  mem_addr,         32'd100);
      post();
      drv(0, 0, 1, 96, 1, 0, 0, 0); step();
      drv(0, 0, 0, 0, 0, 0, 1, 8'hD0);
      pre();
      chk("restart_we",   32'(mem_we), 32'd1);
      chk("restart_addr", mem_addr,    32'd96);
      post();
      for (int b = 1; b < 4; b++) begin
         drv(0, 0, 0, 0, 0, 0, 1, 8'(8'hD0 + b)); step();
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      pre();
      chk("restart_done", 32'(load_done), 32'd1);
      post();
      chk("restart_word", rd_word(96), 32'hD3D2D1D0);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] fa, b;
         case ($urandom_range(0, 3))
            0:       fa = $urandom_range(0, DEPTH/4 - 1) * 4;
            1:       fa = $urandom;
            2:       fa = DEPTH - 4 + $urandom_range(0, 8);
            default: fa = $urandom_range(0, DEPTH - 1);
         endcase
         if ($urandom_range(0, 3) != 0) b = $urandom_range(0, DEPTH/4 - 1) * 4;
         else                           b = $urandom_range(0, DEPTH + 8);
         drv(($urandom_range(0, 499) == 0), fa, ($urandom_range(0, 15) == 0), b,
             WCW'($urandom_range(0, 6)), ($urandom_range(0, 99) < 2),
             ($urandom_range(0, 9) < 7), 8'($urandom));
         step();
      end

      // Whole memory image against the model's image
      for (int a = 0; a < DEPTH; a += 4)
         chk($sformatf("image_%0d", a), rd_word(a),
             {exp_mem[a+3], exp_mem[a+2], exp_mem[a+1], exp_mem[a]});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Owns the single address/write port of the 4-lane (byte-per-RAM) instruction memory.
- Shares that port between two users:
  - the core fetch path (read-only);
  - a byte-serial program loader (valid/ready stream) that writes the image into the memory in place.
- Sits between the fetch stage, the boot/debug byte source and the instruction memory.
- Stalls fetch while a load is active and flags bad fetch addresses.

Parameters:
- INST_MEM_DEPTH, 2048, memory size in bytes; must be a multiple of 4.
- WORD_CNT_W, 10, width of the word counters; must satisfy 2^WORD_CNT_W >= INST_MEM_DEPTH/4 + 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- fetch_addr  input  32  byte address requested by fetch.
- fetch_grant  output  1  1 = mem_addr carries fetch_addr this cycle; 0 = fetch must stall.
- fetch_fault  output  1  registered; high the cycle after a granted fetch with a bad address.
- load_start  input  1  one-cycle pulse that begins a load.
- load_base  input  32  byte start address of the load.
- load_words  input  WORD_CNT_W  number of 32-bit words to load.
- load_abort  input  1  cancels an active load.
- byte_valid  input  1  loader byte present.
- byte_data  input  8  loader byte.
- byte_ready  output  1  arbiter accepts byte this cycle.
- mem_addr  output  32  word-aligned byte address to the instruction memory.
- mem_we  output  4  per-lane write enable; bit k drives byte lane k (bits 8k+7:8k).
- mem_wdata  output  32  write data = {4{byte_data}}.
- load_busy  output  1  high in LOAD and DRAIN.
- load_done  output  1  one-cycle pulse on successful completion.
- load_err  output  1  one-cycle pulse on a rejected load_start.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; lane and word counters cleared.
  - fetch_fault, load_done, load_err, byte_ready and mem_we all 0; load_busy=0.
  - Takes effect mid-load; partially written words are left as written.
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - fetch_grant=1; mem_addr={fetch_addr[31:2],2'b00}; mem_we=0; byte_ready=0.
  - On load_start, load_base and load_words are validated. The request is valid when:
    - load_base[1:0]==0;
    - load_words!=0;
    - load_base + 4*load_words <= INST_MEM_DEPTH.
  - Valid request: latch base and count, clear counters, go to LOAD next cycle.
  - Invalid request: pulse load_err next cycle and stay in IDLE.
- LOAD:
  - fetch_grant=0; byte_ready=1; mem_addr=base + 4*word_cnt.
  - When byte_valid && byte_ready, in the same cycle: mem_we = one-hot(lane_cnt), and mem_wdata carries the byte.
  - Byte order is little-endian: the first byte of each word goes to lane 0.
  - lane_cnt increments on each accepted byte and wraps 3 -> 0. On wrap, word_cnt increments.
  - Accepting byte 3 of the last word (word_cnt==count-1) moves the FSM to DRAIN.
  - If byte_valid=0, nothing is written and counters hold.
- DRAIN:
  - One cycle; fetch_grant=0; byte_ready=0; mem_we=0.
  - Pulse load_done for exactly this cycle, then go to IDLE.
  - Guarantees the final write commits before fetch resumes.
- load_abort in LOAD:
  - Takes priority over a byte arriving the same cycle: that byte is not written and byte_ready=0 that cycle.
  - Next state is IDLE, with no load_done and no load_err.
- load_start outside IDLE is ignored.
- fetch_fault:
  - Set on the edge after an IDLE cycle where fetch_addr[1:0]!=0 or fetch_addr >= INST_MEM_DEPTH; otherwise cleared.
  - Aligns with the memory's 1-cycle registered read data.
  - mem_addr still carries the masked address; the read data is undefined and must be discarded.
- Address arithmetic is 32-bit unsigned. The bound check must not overflow: compare in 33 bits.

Test Plan:
- Fetch passthrough: IDLE, fetch_addr=0, then 4, then 2044 -> fetch_grant=1, mem_addr=0/4/2044, fetch_fault=0 each following cycle.
- Bad fetch: fetch_addr=5 then 2048 -> mem_addr=4 then 2048; fetch_fault=1 on each next cycle.
- Load: load_base=8, load_words=2, bytes 0x11..0x18 streamed with gaps.
  - mem_we sequence 0001,0010,0100,1000 at mem_addr=8, then the same lanes at 12.
  - load_done pulses once; fetch_grant=0 throughout LOAD/DRAIN.
  - Read-back at 8 = 0x14131211 and at 12 = 0x18171615.
- Rejects: load_words=0; load_base=6; load_base=2044 with load_words=2 -> load_err pulse, state stays IDLE, mem_we never asserted.
- Abort: abort asserted in the same cycle as the 3rd byte of the first word -> that byte is not written; IDLE next cycle; fetch_grant=1; no load_done.
- Reset mid-load: rst=1 after 5 accepted bytes -> next cycle all outputs at reset values and fetch_grant=1. A new load then restarts at lane 0.
